emboss_frame_ctrl: RTL and testbench

Frame-level sequencer for the combinational 3x3 emboss kernel. It scans an `IMG_W` x `IMG_H` grayscale frame in raster order and fetches source pixels from a synchronous read memory. It builds a sliding 3x3 window, presents that window to an external `emboss_core`, and writes each output pixel to a destination memory through a ready/valid write port. Border pixels bypass the kernel. This block replaces the behavioural scan loop used by the file-I/O benches and is the synthesizable front end of the emboss path.

---
 rtl/emboss_frame_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_emboss_frame_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/emboss_frame_ctrl.sv
// emboss_frame_ctrl: raster-scan frame sequencer for the external 3x3 emboss core.
// Reads source pixels from a 1-cycle-latency memory and builds a sliding 3x3 window.
// It writes one destination pixel per frame address, in ascending order.
// Optional feature macro: EMBOSS_BORDER_COPY_EN. When defined, border pixels are
// copied from the source instead of being written as BORDER_VAL.
// Write handshake: a transfer happens on a cycle where wr_en & wr_ready. Once wr_en
// rises, wr_en, wr_addr, wr_data and the window p00..p22 hold steady until that transfer.
module emboss_frame_ctrl #(
    parameter int         IMG_W      = 630,
    parameter int         IMG_H      = 630,
    parameter int         ADDR_W     = 19,
    parameter logic [7:0] BORDER_VAL = 8'd128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic [7:0]        p00,
    output logic [7:0]        p01,
    output logic [7:0]        p02,
    output logic [7:0]        p10,
    output logic [7:0]        p11,
    output logic [7:0]        p12,
    output logic [7:0]        p20,
    output logic [7:0]        p21,
    output logic [7:0]        p22,
    input  logic [7:0]        core_pix,
    output logic [2:0]        dbg_state_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BORD  = 3'd1;
    localparam logic [2:0] S_PRIME = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_CAP   = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
    localparam logic [XW-1:0]     X_PEN  = XW'(IMG_W - 2);
    localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW1   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW2   = ADDR_W'(2 * IMG_W);
    // Offset from the centre pixel to the upper-left neighbour.
    localparam logic [ADDR_W-1:0] UL_OFF = ADDR_W'(IMG_W + 1);

    logic [2:0]        state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;     // always y*IMG_W + x
    logic [2:0]        step_q, step_d;     // read index inside PRIME / FETCH
    logic              cap_v_q, cap_v_d;   // a read was issued last cycle
    logic [1:0]        cap_row_q, cap_row_d;
    logic [1:0]        cap_col_q, cap_col_d;
    logic [7:0]        win_q [0:2][0:2];
    logic [7:0]        win_d [0:2][0:2];

`ifdef EMBOSS_BORDER_COPY_EN
    logic              bord_ph_q, bord_ph_d;     // 0: read border pixel, 1: write it
    logic              bord_lat_q, bord_lat_d;   // returned datum already latched
    logic [7:0]        bord_data_q, bord_data_d;
`endif

    logic              adv;
    logic              rd_en_c;
    logic [1:0]        rd_row;
    logic [1:0]        rd_col;
    logic [ADDR_W-1:0] row_off;

    // Next-state logic: scan sequencing, read issue and window capture/shift.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        step_d    = step_q;
        cap_v_d   = 1'b0;
        cap_row_d = cap_row_q;
        cap_col_d = cap_col_q;
        win_d     = win_q;
        adv       = 1'b0;
        rd_en_c   = 1'b0;
        rd_row    = 2'd0;
        rd_col    = 2'd0;
`ifdef EMBOSS_BORDER_COPY_EN
        bord_ph_d   = bord_ph_q;
        bord_lat_d  = bord_lat_q;
        bord_data_d = bord_data_q;
`endif

        if (cap_v_q) begin
            win_d[cap_row_q][cap_col_q] = rd_data;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    step_d  = '0;
                    state_d = S_BORD;   // (0,0) is always a border pixel
                end
            end
            S_BORD: begin
`ifdef EMBOSS_BORDER_COPY_EN
                if (!bord_ph_q) begin
                    rd_en_c   = 1'b1;
                    bord_ph_d = 1'b1;
                end else if (wr_ready) begin
                    adv        = 1'b1;
                    bord_ph_d  = 1'b0;
                    bord_lat_d = 1'b0;
                end else if (!bord_lat_q) begin
                    bord_data_d = rd_data;
                    bord_lat_d  = 1'b1;
                end
`else
                if (wr_ready) begin
                    adv = 1'b1;
                end
`endif
            end
            S_PRIME: begin
                rd_en_c = 1'b1;
                case (step_q)
                    3'd0:    begin rd_row = 2'd0; rd_col = 2'd0; end
                    3'd1:    begin rd_row = 2'd1; rd_col = 2'd0; end
                    3'd2:    begin rd_row = 2'd2; rd_col = 2'd0; end
                    3'd3:    begin rd_row = 2'd0; rd_col = 2'd1; end
                    3'd4:    begin rd_row = 2'd1; rd_col = 2'd1; end
                    default: begin rd_row = 2'd2; rd_col = 2'd1; end
                endcase
                cap_v_d   = 1'b1;
                cap_row_d = rd_row;
                cap_col_d = rd_col;
                if (step_q == 3'd5) begin
                    step_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_FETCH: begin
                rd_en_c   = 1'b1;
                rd_row    = step_q[1:0];
                rd_col    = 2'd2;
                cap_v_d   = 1'b1;
                cap_row_d = rd_row;
                cap_col_d = rd_col;
                if (step_q == 3'd2) begin
                    step_d  = '0;
                    state_d = S_CAP;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_CAP: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wr_ready) begin
                    for (int r = 0; r < 3; r++) begin
                        win_d[r][0] = win_q[r][1];
                        win_d[r][1] = win_q[r][2];
                    end
                    adv = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (adv) begin
            if (x_q == X_LAST) begin
                if (y_q == Y_LAST) begin
                    state_d = S_DONE;
                end else begin
                    x_d     = '0;
                    y_d     = y_q + YW'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_BORD;
                end
            end else begin
                x_d    = x_q + XW'(1);
                addr_d = addr_q + ADDR_W'(1);
                if (y_q == '0 || y_q == Y_LAST || x_q == X_PEN) begin
                    state_d = S_BORD;
                end else if (x_q == '0) begin
                    state_d = S_PRIME;
                end else begin
                    state_d = S_FETCH;
                end
            end
        end
    end

    // Output decode: status, read port and write port, all zero while idle.
    always_comb begin
        busy    = (state_q == S_BORD) || (state_q == S_PRIME) || (state_q == S_FETCH) ||
                  (state_q == S_CAP)  || (state_q == S_WRITE);
        done    = (state_q == S_DONE);
        rd_en   = rd_en_c;
        row_off = '0;
        case (rd_row)
            2'd1:    row_off = ROW1;
            2'd2:    row_off = ROW2;
            default: row_off = '0;
        endcase
        rd_addr = '0;
        if (rd_en_c) begin
            if (state_q == S_BORD) begin
                rd_addr = addr_q;
            end else begin
                rd_addr = addr_q - UL_OFF + row_off + ADDR_W'(rd_col);
            end
        end
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            S_BORD: begin
`ifdef EMBOSS_BORDER_COPY_EN
                if (bord_ph_q) begin
                    wr_en   = 1'b1;
                    wr_addr = addr_q;
                    wr_data = bord_lat_q ? bord_data_q : rd_data;
                end
`else
                wr_en   = 1'b1;
                wr_addr = addr_q;
                wr_data = BORDER_VAL;
`endif
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = addr_q;
                wr_data = core_pix;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            step_q    <= '0;
            cap_v_q   <= 1'b0;
            cap_row_q <= '0;
            cap_col_q <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
`ifdef EMBOSS_BORDER_COPY_EN
            bord_ph_q   <= 1'b0;
            bord_lat_q  <= 1'b0;
            bord_data_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
            step_q    <= step_d;
            cap_v_q   <= cap_v_d;
            cap_row_q <= cap_row_d;
            cap_col_q <= cap_col_d;
            win_q     <= win_d;
`ifdef EMBOSS_BORDER_COPY_EN
            bord_ph_q   <= bord_ph_d;
            bord_lat_q  <= bord_lat_d;
            bord_data_q <= bord_data_d;
`endif
        end
    end

    assign p00 = win_q[0][0];
    assign p01 = win_q[0][1];
    assign p02 = win_q[0][2];
    assign p10 = win_q[1][0];
    assign p11 = win_q[1][1];
    assign p12 = win_q[1][2];
    assign p20 = win_q[2][0];
    assign p21 = win_q[2][1];
    assign p22 = win_q[2][2];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_emboss_frame_ctrl.sv
// tb_emboss_frame_ctrl: directed frame sequence with random source data and write
// backpressure. Expected writes come from a frame-level model of the emboss path.
// The DUT handshake is wr_en & wr_ready; data, address and window must hold while stalled.
module tb_emboss_frame_ctrl;

    localparam int W  = 6;
    localparam int H  = 4;
    localparam int AW = 5;
    localparam int N  = W * H;
    localparam int EW = AW + 8;
    localparam int B  = 2 * W + 2 * H - 4;
`ifdef EMBOSS_BORDER_COPY_EN
    localparam int BCOST  = 2;
    localparam int BREADS = B;
`else
    localparam int BCOST  = 1;
    localparam int BREADS = 0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic [7:0]    p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic [7:0]    core_pix;
    logic [2:0]    dbg_state;

    logic [7:0]    src [0:(1<<AW)-1];
    logic [EW-1:0] exp_q[$];
    int            total = 0;
    int            bad   = 0;
    int            rdy_mode = 0;
    bit            sb_on = 0;
    int            n_wr, n_rd, n_busy, n_done, n_stall;

    emboss_frame_ctrl #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .BORDER_VAL(8'd128)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .p00(p00), .p01(p01), .p02(p02), .p10(p10), .p11(p11), .p12(p12),
        .p20(p20), .p21(p21), .p22(p22), .core_pix(core_pix), .dbg_state_o(dbg_state)
    );

    // Emboss core model: weighted difference across the diagonal, clamped to 0..255.
    function automatic logic [7:0] kern(input int a00, input int a01, input int a02,
                                        input int a10, input int a11, input int a12,
                                        input int a20, input int a21, input int a22);
        int s;
        s = 2 * a22 + a21 + a12 + a11 - 2 * a00 - a01 - a10 + (a02 / 4) - (a20 / 4);
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

    assign core_pix = kern(p00, p01, p02, p10, p11, p12, p20, p21, p22);

    function automatic bit is_border(input int a);
        int x, y;
        x = a % W;
        y = a / W;
        return (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
    endfunction

    function automatic logic [7:0] exp_pix(input int a);
        if (is_border(a)) begin
`ifdef EMBOSS_BORDER_COPY_EN
            return src[a];
`else
            return 8'd128;
`endif
        end
        return kern(src[a-W-1], src[a-W], src[a-W+1], src[a-1], src[a], src[a+1],
                    src[a+W-1], src[a+W], src[a+W+1]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_win"}, {p00, p01, p02, p10}, 0);
        chk({tag, "_win2"}, {p11, p12, p20, p21, p22}, 0);
    endtask

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source memory: data appears the cycle after rd_en, garbage otherwise.
    initial begin : src_mem_drv
        bit            pend;
        logic [AW-1:0] a;
        rd_data = '0;
        forever begin
            @(negedge clk);
            pend = rd_en;
            a    = rd_addr;
            @(posedge clk);
            #1;
            rd_data = pend ? src[a] : 8'($urandom);
        end
    end

    // Destination ready: always, toggling, or random.
    initial begin : ready_drv
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = ~wr_ready;
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard / monitor, sampled on the falling edge.
    initial begin : monitor
        logic [EW-1:0] e;
        int            ea, ax, ay;
        logic [7:0]    pw [9];
        forever begin
            @(negedge clk);
            if (sb_on) begin
                if (busy) n_busy++;
                if (done) n_done++;
                if (rd_en) begin
                    n_rd++;
                    chk("rd_addr_range", 32'(rd_addr < AW'(N)), 1);
                end
                if (wr_en) begin
                    chk("no_rd_during_wr", rd_en, 0);
                    if (exp_q.size() == 0) begin
                        chk("wr_beyond_frame", wr_en, 0);
                    end else begin
                        e  = exp_q[0];
                        ea = int'(e[EW-1:8]);
                        chk("wr_addr", wr_addr, e[EW-1:8]);
                        chk($sformatf("wr_data@%0d", ea), wr_data, e[7:0]);
                        if (!is_border(ea)) begin
                            ax = ea % W;
                            ay = ea / W;
                            pw = '{p00, p01, p02, p10, p11, p12, p20, p21, p22};
                            for (int r = 0; r < 3; r++) begin
                                for (int c = 0; c < 3; c++) begin
                                    chk($sformatf("win%0d%0d@%0d", r, c, ea), pw[r*3+c],
                                        src[(ay - 1 + r) * W + ax - 1 + c]);
                                end
                            end
                        end
                        if (wr_ready) begin
                            void'(exp_q.pop_front());
                            n_wr++;
                        end else begin
                            n_stall++;
                        end
                    end
                end
            end
        end
    end

    task automatic fill_src(input int pat);
        for (int a = 0; a < (1 << AW); a++) begin
            if (a >= N)        src[a] = 8'd0;
            else if (pat == 0) src[a] = 8'h40;
            else if (pat == 1) src[a] = 8'(a);
            else               src[a] = 8'($urandom_range(0, 255));
        end
    endtask

    // One full frame: build expectations, start, wait bounded for done, check totals.
    task automatic run_frame(input int pat, input int rmode, input bit poke);
        int cyc;
        fill_src(pat);
        exp_q.delete();
        for (int a = 0; a < N; a++) exp_q.push_back({AW'(a), exp_pix(a)});
        n_wr = 0; n_rd = 0; n_busy = 0; n_done = 0; n_stall = 0;
        rdy_mode = rmode;
        sb_on = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("first_wr_en", wr_en, 1);
        chk("first_wr_addr", wr_addr, 0);
        cyc = 0;
        while (n_done == 0 && cyc < 2000) begin
            start = (poke && cyc == 15) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", n_done, 1);
        repeat (3) @(negedge clk);
        chk("done_once", n_done, 1);
        chk("idle_after_done", busy, 0);
        chk("wr_count", n_wr, N);
        chk("exp_left", exp_q.size(), 0);
        chk("busy_cycles", n_busy, B * BCOST + (H - 2) * (11 + 5 * (W - 3)) + n_stall);
        chk("rd_count", n_rd, (H - 2) * (6 + 3 * (W - 2)) + BREADS);
        sb_on = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_frame(0, 0, 1'b0);   // flat frame
        run_frame(1, 0, 1'b0);   // ramp: window must match neighbourhood
        run_frame(0, 1, 1'b0);   // backpressure toggling
        run_frame(2, 2, 1'b0);   // random data, random backpressure
        run_frame(2, 0, 1'b1);   // start pulsed while busy

        // Reset in the middle of a frame.
        fill_src(2);
        rdy_mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_done", done, 0);
            chk("post_reset_wr_en", wr_en, 0);
            chk("post_reset_rd_en", rd_en, 0);
        end
        run_frame(2, 1, 1'b0);   // fresh frame after abandoned one

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
